serial_rx_deser: RTL and testbench
==================================

Name: serial_rx_deser

Overview:
- Serial-to-parallel receiver that deserializes frames produced by the team's parallel-load, MSB-first shift-out register.
- Recovers N data bits plus an even-parity bit from a single serial line, sampled on a bit-enable strobe.
- Presents each word on a valid/ready holding register.
- Sits at the receiving end of the inter-board serial link, feeding the command decoder.

Parameters:
N, 12, data bits per frame (N >= 2)
CW, 4, bit-counter width; must satisfy 2^CW > N

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising clk edge
sin  input  1  serial line; idles 0
bit_en  input  1  sample strobe; sin is examined only on cycles where bit_en=1
q  output  N  received word, MSB = first data bit received
out_valid  output  1  q holds an unconsumed word
out_ready  input  1  consumer accepts q when out_valid && out_ready
parity_err  output  1  parity status of the word currently in q (valid while out_valid=1)
overrun  output  1  sticky: a completed frame was dropped because the holding register was full
busy  output  1  receiver is in DATA or PARITY state

Behaviour:
- Reset (sync, active-high) forces the following on the next rising clk edge, regardless of other inputs:
  - state=IDLE, bit counter=0, shift register=0.
  - q=0, out_valid=0, parity_err=0, overrun=0, busy=0.
  - A frame in progress is discarded.
- Frame format on the line, one bit per bit_en cycle:
  - start bit = 1;
  - N data bits, MSB first;
  - parity bit = XOR of the N data bits (even parity);
  - line then returns to idle 0.
- Cycles with bit_en=0 never change state, counter or shift register. The consumer handshake still operates on those cycles.
- State machine (all transitions only on bit_en=1 unless noted):
  - IDLE: sin=1 -> DATA, counter=0. sin=0 -> stay IDLE.
  - DATA: shift register <= {sr[N-2:0], sin}; running parity ^= sin; counter++. When counter was N-1 -> PARITY.
  - PARITY: compare sin with running parity, then -> IDLE. The next start bit is accepted on the very next bit_en after the parity bit; no idle gap is required.
- Frame completion happens on the bit_en cycle that samples the parity bit:
  - out_valid=0, or out_valid=1 && out_ready=1 in the same cycle: q <= assembled word, parity_err <= (sin != running parity), out_valid <= 1.
  - out_valid=1 && out_ready=0: the new word is dropped; q and parity_err are unchanged; overrun <= 1.
- Handshake:
  - out_valid falls on the clock edge after a cycle with out_valid && out_ready, unless a new word lands on that same edge, in which case out_valid stays 1.
  - q is stable while out_valid=1 and not accepted.
- overrun is sticky and cleared only by reset.
- Latency: q and out_valid update on the clk edge that samples the parity bit. That is N+2 bit_en cycles after the start bit is sampled, counting the start bit as bit_en cycle 1.
- busy=1 in DATA and PARITY; 0 in IDLE.
- A parity error does not block delivery; the word is delivered with parity_err=1.
- Reset asserted mid-frame or on a bit_en cycle has priority over every other action.

Test Plan:
- Reset, then frame start=1, data=12'hA5C, parity=0, with bit_en=1 every cycle and out_ready=0. Required: q=12'hA5C, out_valid=1, parity_err=0 on the edge of the 14th bit_en cycle; busy=1 during cycles 1..13.
- Same frame with parity bit=1 and bit_en asserted only every 4th cycle. Required: q=12'hA5C, parity_err=1, delivered at cycle 4*14; state frozen on cycles with bit_en=0.
- First word 12'h001 held (out_ready=0), then second frame 12'hFFF completes. Required: q remains 12'h001, overrun=1. Then pulse out_ready=1: out_valid=0 on the next edge, overrun stays 1.
- Back-to-back frames 12'h123 then 12'h456 with no idle gap, and out_ready=1 on the completion cycle of the second frame. Required: q changes 12'h123 -> 12'h456 with out_valid continuously 1 and overrun=0.
- Reset asserted after 6 data bits of a frame. Required: next edge busy=0, out_valid=0, q=0. A following clean frame 12'h800 is received correctly.
- Line held 0 for 50 bit_en cycles. Required: stays IDLE, busy=0, out_valid=0.

Source files
------------

// File: rtl/serial_rx_deser_if.sv
// Serial receive link bundle: line input, sample strobe, and the word-holding handshake.
// The master side is the receiver; the slave side is the line driver and word consumer.
interface serial_rx_deser_if #(
  parameter int N = 12
);
  logic         sin;
  logic         bit_en;
  logic [N-1:0] q;
  logic         out_valid;
  logic         out_ready;
  logic         parity_err;
  logic         overrun;
  logic         busy;

  modport master (
    input  sin, bit_en, out_ready,
    output q, out_valid, parity_err, overrun, busy
  );

  modport slave (
    output sin, bit_en, out_ready,
    input  q, out_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/serial_rx_deser.sv
// Serial-to-parallel receiver: start bit, N data bits MSB first, even parity,
// delivered into a valid/ready holding register with sticky overrun.
module serial_rx_deser #(
  parameter int N  = 12,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             reset,
  serial_rx_deser_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          par_q, par_d;
  logic [N-1:0]  word_q, word_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;

  // NOTE: every signal gets its hold value first, so no path through this block leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    word_d  = word_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;

    // Consumer handshake runs every cycle; a landing word below overrides the drop.
    if (valid_q && bus.out_ready) valid_d = 1'b0;

    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sin) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          sr_d  = {sr_q[N-2:0], bus.sin};
          par_d = par_q ^ bus.sin;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_d = PARITY;
        end
        PARITY: begin
          state_d = IDLE;
          if (!valid_q || bus.out_ready) begin
            word_d  = sr_q;
            perr_d  = (bus.sin != par_q);
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the shift register is cleared too, so a discarded partial frame leaves no residue.
      sr_q    <= '0;
      par_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.q          = word_q;
  assign bus.out_valid  = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_deser.sv
// Directed bench for serial_rx_deser: a table of whole frames plus hand-written
// overrun, back-to-back, mid-frame reset and idle-line sequences.
module tb_serial_rx_deser;
  localparam int N  = 12;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  serial_rx_deser_if #(.N(N)) bus ();

  serial_rx_deser #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    logic         flip_par;
    int           period;
    logic [N-1:0] exp_q;
    logic         exp_perr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.sin       = 1'b1;
    bus.bit_en    = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    bus.sin    = 1'b0;
    bus.bit_en = 1'b0;
  endtask

  // Gap cycles drive sin=1 with bit_en=0; the receiver must ignore them.
  task automatic send_bit(input logic b, input int period, input logic gap_busy);
    for (int g = 1; g < period; g++) begin
      bus.sin    = 1'b1;
      bus.bit_en = 1'b0;
      tick();
      check("gap_busy_frozen", bus.busy, gap_busy);
    end
    bus.sin    = b;
    bus.bit_en = 1'b1;
    tick();
    bus.bit_en = 1'b0;
    bus.sin    = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] data, input logic flip_par, input int period,
                            input logic ready_last, input logic pre_valid);
    logic p;
    p = (^data) ^ flip_par;
    send_bit(1'b1, period, 1'b0);
    check("busy_after_start", bus.busy, 1);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(data[i], period, 1'b1);
      check("busy_in_data", bus.busy, 1);
      check("valid_before_parity", bus.out_valid, pre_valid);
    end
    for (int g = 1; g < period; g++) begin
      bus.sin = 1'b1;
      tick();
      check("parity_gap_busy", bus.busy, 1);
    end
    bus.sin       = p;
    bus.bit_en    = 1'b1;
    bus.out_ready = ready_last;
    tick();
    bus.bit_en    = 1'b0;
    bus.sin       = 1'b0;
    bus.out_ready = 1'b0;
    check("busy_after_parity", bus.busy, 0);
    check("valid_after_parity", bus.out_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 12'hA5C, flip_par: 1'b0, period: 1, exp_q: 12'hA5C, exp_perr: 1'b0};
    vecs[1] = '{data: 12'hA5C, flip_par: 1'b1, period: 4, exp_q: 12'hA5C, exp_perr: 1'b1};
    vecs[2] = '{data: 12'h800, flip_par: 1'b0, period: 1, exp_q: 12'h800, exp_perr: 1'b0};
    vecs[3] = '{data: 12'h000, flip_par: 1'b1, period: 2, exp_q: 12'h000, exp_perr: 1'b1};
    vecs[4] = '{data: 12'hFFF, flip_par: 1'b0, period: 3, exp_q: 12'hFFF, exp_perr: 1'b0};

    reset         = 1'b0;
    bus.sin       = 1'b0;
    bus.bit_en    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, applied while the line shows a start bit on a strobe cycle.
    do_reset();
    check("rst_q", bus.q, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);

    // Table of single frames, held then consumed.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_frame(vecs[v].data, vecs[v].flip_par, vecs[v].period, 1'b0, 1'b0);
      check("tbl_q", bus.q, vecs[v].exp_q);
      check("tbl_perr", bus.parity_err, vecs[v].exp_perr);
      check("tbl_overrun", bus.overrun, 0);
      repeat (3) tick();
      check("tbl_q_held", bus.q, vecs[v].exp_q);
      check("tbl_valid_held", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("tbl_valid_consumed", bus.out_valid, 0);
    end

    // Overrun: second word dropped while the first is held.
    do_reset();
    send_frame(12'h001, 1'b0, 1, 1'b0, 1'b0);
    send_frame(12'hFFF, 1'b0, 1, 1'b0, 1'b1);
    check("ovr_q_kept", bus.q, 12'h001);
    check("ovr_perr_kept", bus.parity_err, 0);
    check("ovr_flag", bus.overrun, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ovr_valid_drop", bus.out_valid, 0);
    check("ovr_sticky", bus.overrun, 1);
    repeat (2) tick();
    check("ovr_sticky_later", bus.overrun, 1);

    // Back-to-back frames, second completes while the first is accepted.
    do_reset();
    send_frame(12'h123, 1'b0, 1, 1'b0, 1'b0);
    check("b2b_q1", bus.q, 12'h123);
    send_frame(12'h456, 1'b0, 1, 1'b1, 1'b1);
    check("b2b_q2", bus.q, 12'h456);
    check("b2b_perr", bus.parity_err, 0);
    check("b2b_overrun", bus.overrun, 0);

    // Reset after six data bits, with a word already held.
    do_reset();
    send_frame(12'h3C5, 1'b0, 1, 1'b0, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1, 1'b1);
    check("mid_busy_before", bus.busy, 1);
    reset      = 1'b1;
    bus.sin    = 1'b1;
    bus.bit_en = 1'b1;
    tick();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_q", bus.q, 0);
    reset      = 1'b0;
    bus.sin    = 1'b0;
    bus.bit_en = 1'b0;
    tick();
    send_frame(12'h800, 1'b0, 1, 1'b0, 1'b0);
    check("mid_clean_q", bus.q, 12'h800);
    check("mid_clean_perr", bus.parity_err, 0);

    // Idle line for 50 strobes.
    do_reset();
    bus.sin    = 1'b0;
    bus.bit_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_busy", bus.busy, 0);
    end
    bus.bit_en = 1'b0;
    check("idle_valid", bus.out_valid, 0);
    check("idle_q", bus.q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
